approx_mult_pipe: RTL and testbench

APPROX_MULT_PIPE -- requirements
Module: approx_mult_pipe

---
 rtl/approx_mult_pipe.sv | 123 ++++++++++++
 tb/tb_approx_mult_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: unsigned W x W multiplier; any of the four half-width quadrant products can have its low TRUNC bits zeroed (mode mask).
// Latency: 3 advancing cycles (S1 operands, S2 quadrant products, S3 sum); throughput one result per cycle.
// Backpressure: a single global advance; the whole pipe holds while out_valid && !out_ready, and in_ready follows it.
// Optional: define APPROX_MULT_ERRSTAT_EN to add the err and approx_cnt outputs.
module approx_mult_pipe #(
    parameter int W     = 8,
    parameter int TRUNC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic [3:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   R
`ifdef APPROX_MULT_ERRSTAT_EN
    ,
    output logic [2*W-1:0]   err,
    output logic [15:0]      approx_cnt
`endif
);

    localparam int H  = W / 2;
    localparam int WW = 2 * W;
    localparam logic [W-1:0] TMASK = (TRUNC >= W) ? '0 : ({W{1'b1}} << TRUNC);

    logic          adv;
    logic          v1_q, v2_q, v3_q;
    logic [W-1:0]  a1_q, b1_q;
    logic [3:0]    m1_q;
    logic [W-1:0]  ll_q, lh_q, hl_q, hh_q;
    logic [W-1:0]  ll_d, lh_d, hl_d, hh_d;
    logic [WW-1:0] r_q, r_d;

    assign adv       = !v3_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign R         = r_q;

    always_comb begin
        ll_d = W'(a1_q[H-1:0]) * W'(b1_q[H-1:0]);
        lh_d = W'(a1_q[H-1:0]) * W'(b1_q[W-1:H]);
        hl_d = W'(a1_q[W-1:H]) * W'(b1_q[H-1:0]);
        hh_d = W'(a1_q[W-1:H]) * W'(b1_q[W-1:H]);
        if (m1_q[0]) ll_d = ll_d & TMASK;
        if (m1_q[1]) lh_d = lh_d & TMASK;
        if (m1_q[2]) hl_d = hl_d & TMASK;
        if (m1_q[3]) hh_d = hh_d & TMASK;
    end

    // Full 2W-bit sum so carries out of the cross terms are never dropped.
    assign r_d = WW'(ll_q) + (WW'(lh_q) << H) + (WW'(hl_q) << H) + (WW'(hh_q) << W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            a1_q <= '0;
            b1_q <= '0;
            m1_q <= '0;
            ll_q <= '0;
            lh_q <= '0;
            hl_q <= '0;
            hh_q <= '0;
            r_q  <= '0;
        end else if (adv) begin
            v1_q <= in_valid;
            a1_q <= A;
            b1_q <= B;
            m1_q <= mode;
            v2_q <= v1_q;
            ll_q <= ll_d;
            lh_q <= lh_d;
            hl_q <= hl_d;
            hh_q <= hh_d;
            v3_q <= v2_q;
            r_q  <= r_d;
        end
    end

`ifdef APPROX_MULT_ERRSTAT_EN
    logic [WW-1:0] exact2_q, exact2_d;
    logic [WW-1:0] err_q, err_d;
    logic          nz2_q, nz3_q;
    logic [15:0]   cnt_q, cnt_d;

    assign exact2_d = WW'(a1_q) * WW'(b1_q);
    assign err_d    = exact2_q - r_d;

    always_comb begin
        cnt_d = cnt_q;
        if (v3_q && out_ready && nz3_q && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    // Error and mode flag travel alongside R so they describe the result currently on R.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exact2_q <= '0;
            nz2_q    <= 1'b0;
            err_q    <= '0;
            nz3_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (adv) begin
                exact2_q <= exact2_d;
                nz2_q    <= (m1_q != 4'd0);
                err_q    <= err_d;
                nz3_q    <= nz2_q;
            end
        end
    end

    assign err        = err_q;
    assign approx_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Bench for approx_mult_pipe (W=8, TRUNC=3): directed vectors, streaming, stall, mid-flight reset and random traffic against a reference model.
module tb_approx_mult_pipe;

    localparam int W     = 8;
    localparam int TRUNC = 3;
    localparam int H     = W / 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic [3:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   R;
`ifdef APPROX_MULT_ERRSTAT_EN
    logic [2*W-1:0]   err;
    logic [15:0]      approx_cnt;
`endif

    int tests = 0;
    int fails = 0;

    approx_mult_pipe #(.W(W), .TRUNC(TRUNC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .R(R)
`ifdef APPROX_MULT_ERRSTAT_EN
        , .err(err), .approx_cnt(approx_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Quadrant products computed with integer arithmetic; truncation is "subtract remainder mod 2^TRUNC".
    function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] m);
        longint hb, al, ah, bl, bh, s;
        longint qp [4];
        hb = longint'(1) << H;
        al = a % hb; ah = a / hb; bl = b % hb; bh = b / hb;
        qp[0] = al * bl; qp[1] = al * bh; qp[2] = ah * bl; qp[3] = ah * bh;
        for (int i = 0; i < 4; i++)
            if (m[i]) qp[i] = qp[i] - (qp[i] % (longint'(1) << TRUNC));
        s = qp[0] + hb * (qp[1] + qp[2]) + hb * hb * qp[3];
        return (2*W)'(s);
    endfunction

    function automatic logic [2*W-1:0] ref_err(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] m);
        longint ex;
        ex = longint'(a) * longint'(b);
        return (2*W)'(ex - longint'(ref_mult(a, b, m)));
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] m, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        A         = a;
        B         = b;
        mode      = m;
        out_ready = ordy;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; mode = '0; out_ready = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests++; if (R !== '0) begin fails++; $display("FAIL reset_R got %h want 0", R); end
`ifdef APPROX_MULT_ERRSTAT_EN
        tests++; if (err !== '0 || approx_cnt !== 16'd0) begin fails++; $display("FAIL reset_stats got err=%h cnt=%h want 0", err, approx_cnt); end
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [3:0]  md [3] = '{4'h0, 4'h8, 4'hF};
        logic [15:0] rx [3] = '{16'hFE01, 16'hFD01, 16'hFCE0};
        logic [15:0] ex [3] = '{16'h0000, 16'h0100, 16'h0121};
        int lat;
        logic [15:0] got, got_err;
        logic [15:0] cnt0;
        for (int k = 0; k < 3; k++) begin
            cnt0 = '0;
`ifdef APPROX_MULT_ERRSTAT_EN
            cnt0 = approx_cnt;
`endif
            drive(1'b1, 8'hFF, 8'hFF, md[k], 1'b1);
            lat = -1; got = '0; got_err = '0;
            for (int c = 1; c <= 6; c++) begin
                drive(1'b0, '0, '0, '0, 1'b1);
                if (out_valid === 1'b1 && lat < 0) begin
                    lat = c; got = R;
`ifdef APPROX_MULT_ERRSTAT_EN
                    got_err = err;
`endif
                end
            end
            tests++; if (lat != 3) begin fails++; $display("FAIL directed_latency[%0d] got %0d want 3", k, lat); end
            tests++; if (got !== rx[k]) begin fails++; $display("FAIL directed_R[%0d] got %h want %h", k, got, rx[k]); end
`ifdef APPROX_MULT_ERRSTAT_EN
            tests++; if (got_err !== ex[k]) begin fails++; $display("FAIL directed_err[%0d] got %h want %h", k, got_err, ex[k]); end
            tests++; if (approx_cnt !== cnt0 + 16'(md[k] != 4'd0)) begin fails++; $display("FAIL directed_cnt[%0d] got %h want %h", k, approx_cnt, cnt0 + 16'(md[k] != 4'd0)); end
`else
            if (got_err !== '0 || cnt0 !== '0 || ex[k] === 16'hxxxx) ;
`endif
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  ta [4] = '{8'h12, 8'hFF, 8'hFF, 8'hFF};
        logic [7:0]  tb [4] = '{8'h34, 8'hFF, 8'hFF, 8'hFF};
        logic [3:0]  tm [4] = '{4'h0, 4'h0, 4'h8, 4'hF};
        logic [15:0] te [4] = '{16'h03A8, 16'hFE01, 16'hFD01, 16'hFCE0};
        logic exp_v;
        for (int c = 0; c < 10; c++) begin
            if (c < 4) drive(1'b1, ta[c], tb[c], tm[c], 1'b1);
            else       drive(1'b0, '0, '0, '0, 1'b1);
            exp_v = (c >= 3 && c <= 6);
            tests++; if (out_valid !== exp_v) begin fails++; $display("FAIL b2b_valid[c%0d] got %b want %b", c, out_valid, exp_v); end
            if (exp_v && out_valid === 1'b1) begin
                tests++; if (R !== te[c-3]) begin fails++; $display("FAIL b2b_R[c%0d] got %h want %h", c, R, te[c-3]); end
            end
        end
    endtask

    task automatic test_stall;
        logic [15:0] eq [$];
        logic [W-1:0] a, b;
        logic [3:0] m;
        for (int c = 0; c < 3; c++) begin
            a = W'($urandom); b = W'($urandom); m = 4'($urandom);
            drive(1'b1, a, b, m, 1'b0);
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_fill_ready[%0d] got %b want 1", c, in_ready); end
            eq.push_back(ref_mult(a, b, m));
        end
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, W'($urandom), W'($urandom), 4'($urandom), 1'b0);
            tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || R !== eq[0]) begin
                fails++; $display("FAIL stall_hold[%0d] got rdy=%b vld=%b R=%h want rdy=0 vld=1 R=%h", c, in_ready, out_valid, R, eq[0]);
            end
        end
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, '0, '0, '0, 1'b1);
            if (out_valid === 1'b1) begin
                tests++;
                if (eq.size() == 0) begin fails++; $display("FAIL stall_extra got R=%h want no result", R); end
                else if (R !== eq[0]) begin fails++; $display("FAIL stall_drain got %h want %h", R, eq[0]); void'(eq.pop_front()); end
                else void'(eq.pop_front());
            end
        end
        tests++; if (eq.size() != 0) begin fails++; $display("FAIL stall_missing got %0d left want 0", eq.size()); end
    endtask

    task automatic test_reset_midflight;
        logic [W-1:0] a, b;
        logic [3:0] m;
        logic [15:0] e;
        int lat;
        logic [15:0] got;
        drive(1'b1, W'($urandom), W'($urandom), 4'($urandom), 1'b0);
        drive(1'b1, W'($urandom), W'($urandom), 4'($urandom), 1'b0);
        drive(1'b0, '0, '0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b0);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL midrst_pre got vld=%b want 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        tests++; if (R !== '0) begin fails++; $display("FAIL midrst_R got %h want 0", R); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, '0, '0, '0, 1'b1);
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_stale[%0d] got vld=%b want 0", c, out_valid); end
        end
        a = W'($urandom); b = W'($urandom); m = 4'($urandom);
        e = ref_mult(a, b, m);
        drive(1'b1, a, b, m, 1'b1);
        lat = -1; got = '0;
        for (int c = 1; c <= 6; c++) begin
            drive(1'b0, '0, '0, '0, 1'b1);
            if (out_valid === 1'b1 && lat < 0) begin lat = c; got = R; end
        end
        tests++; if (lat != 3 || got !== e) begin fails++; $display("FAIL midrst_after got lat=%0d R=%h want lat=3 R=%h", lat, got, e); end
    endtask

    task automatic test_random;
        logic [15:0] eq [$];
        logic [15:0] ee [$];
        logic prev_stall;
        logic [15:0] prev_r, exp_r, exp_e;
        logic v, ordy;
        logic [W-1:0] a, b;
        logic [3:0] m;
        prev_stall = 1'b0; prev_r = '0;
        for (int c = 0; c < 410; c++) begin
            v    = (c < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
            ordy = (c < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
            a = W'($urandom); b = W'($urandom); m = 4'($urandom);
            drive(v, a, b, m, ordy);
            tests++; if (in_ready !== (!out_valid || out_ready)) begin fails++; $display("FAIL rand_in_ready[c%0d] got %b want %b", c, in_ready, !out_valid || out_ready); end
            if (prev_stall) begin
                tests++; if (out_valid !== 1'b1 || R !== prev_r) begin fails++; $display("FAIL rand_hold[c%0d] got vld=%b R=%h want vld=1 R=%h", c, out_valid, R, prev_r); end
            end
            if (out_valid === 1'b1 && out_ready) begin
                tests++;
                if (eq.size() == 0) begin fails++; $display("FAIL rand_spurious[c%0d] got R=%h want none", c, R); end
                else begin
                    exp_r = eq.pop_front();
                    exp_e = ee.pop_front();
                    if (R !== exp_r) begin fails++; $display("FAIL rand_R[c%0d] got %h want %h", c, R, exp_r); end
`ifdef APPROX_MULT_ERRSTAT_EN
                    tests++; if (err !== exp_e) begin fails++; $display("FAIL rand_err[c%0d] got %h want %h", c, err, exp_e); end
`endif
                end
            end
            if (v && in_ready === 1'b1) begin
                eq.push_back(ref_mult(a, b, m));
                ee.push_back(ref_err(a, b, m));
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_r     = R;
        end
        tests++; if (eq.size() != 0) begin fails++; $display("FAIL rand_missing got %0d left want 0", eq.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
